// File: rtl/ppu_pkg.sv
// Shared types and frame geometry for the PPU framebuffer writer.
// The front/back buffer swap is enabled with `define FB_DOUBLE_BUFFER_EN.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [1:0] {
        F_DRAW   = 2'd0,
        F_DRAIN  = 2'd1,
        F_VBLANK = 2'd2
    } FRAME_STATES_t;

    localparam int unsigned FB_W    = 160;
    localparam int unsigned FB_H    = 144;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 8;

    // Shade for colour index idx is bgp[2*idx+1 : 2*idx].
    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input logic [1:0] idx);
        logic [2:0] msb;
        msb = {idx, 1'b1};
        return bgp[msb -: 2];
    endfunction

endpackage

// File: rtl/ppu_px_fifo.sv
// Synchronous FIFO queueing framebuffer writes; count is the pointer difference
// with one extra wrap bit so full and empty are distinguishable.
module ppu_px_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ppu_frame_writer.sv
// PPU pixel sink: tracks x/y, maps colour through BGP, queues framebuffer writes and
// sequences end-of-frame. `define FB_DOUBLE_BUFFER_EN enables front/back buffer swapping.
module ppu_frame_writer
    import ppu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        px_in,
    input  logic              px_valid,
    input  logic [1:0]        ppu_mode,
    input  logic [7:0]        bgp,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [1:0]        fb_wr_data,
    input  logic              fb_wr_ready,
    output logic              fb_front,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned ENTRY_W = ADDR_W + 2;

    PPU_STATES_t       mode;
    PPU_STATES_t       mode_q;
    FRAME_STATES_t     fstate;
    FRAME_STATES_t     fstate_nx;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              accept;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    logic              vblank_entry;
    logic              line_end;
    logic              done_nx;
    logic              front_q;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] px_addr;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;

    assign mode         = PPU_STATES_t'(ppu_mode);
    assign vblank_entry = (mode == V_BLANK) && (mode_q != V_BLANK);
    assign line_end     = (mode == H_BLANK) && (mode_q == DRAW);
    assign accept       = px_valid && (mode == DRAW) && (x < X_W'(FB_W))
                          && (y < Y_W'(FB_H)) && (fstate == F_DRAW);
    assign pop          = fb_wr_en && fb_wr_ready;
    assign drop         = accept && full && !pop;

`ifdef FB_DOUBLE_BUFFER_EN
    // Writes always target the buffer the display is not reading.
    assign base     = front_q ? '0 : ADDR_W'(FB_SIZE);
    assign fb_front = front_q;
`else
    assign base     = '0;
    assign fb_front = 1'b0;
`endif

    // y*160 as (y<<7)+(y<<5).
    assign row_off = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5);
    assign px_addr = base + row_off + ADDR_W'(x);
    assign din     = {px_addr, bgp_shade(bgp, px_in)};

    ppu_px_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign fb_wr_en   = !empty;
    assign fb_wr_addr = empty ? '0 : dout[ENTRY_W-1:2];
    assign fb_wr_data = empty ? '0 : dout[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            mode_q   <= SCAN;
            overflow <= 1'b0;
        end else begin
            mode_q <= mode;
            if (vblank_entry) begin
                x <= '0;
                y <= '0;
            end else if (line_end) begin
                x <= '0;
                if (y < Y_W'(FB_H)) y <= y + Y_W'(1);
            end else if (accept) begin
                x <= x + X_W'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Frame FSM state register, with the registered end-of-frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate     <= F_DRAW;
            frame_done <= 1'b0;
            front_q    <= 1'b0;
        end else begin
            fstate     <= fstate_nx;
            frame_done <= done_nx;
`ifdef FB_DOUBLE_BUFFER_EN
            if (done_nx) front_q <= !front_q;
`endif
        end
    end

    always_comb begin
        fstate_nx = fstate;
        case (fstate)
            F_DRAW:   if (vblank_entry) fstate_nx = F_DRAIN;
            F_DRAIN:  if (empty) fstate_nx = F_VBLANK;
            F_VBLANK: if (mode != V_BLANK) fstate_nx = F_DRAW;
            default:  fstate_nx = F_DRAW;
        endcase
    end

    // Frame is committed once the drain phase sees an empty queue.
    always_comb begin
        done_nx = 1'b0;
        if (fstate == F_DRAIN && empty) done_nx = 1'b1;
    end

endmodule
